mips32_fetch_queue: RTL
=======================

# mips32_fetch_queue

Instruction-fetch front end for the 32-bit MIPS pipeline. It sits directly upstream of the decode stage and replaces direct `Mem[PC]` fetch with a synchronous instruction-memory port plus a small prefetch FIFO. It delivers `{IR, NPC}` pairs to decode over a valid/ready handshake. It flushes on taken-branch redirect and stops fetching on halt.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and at least 2.
- `AW`, 10: word-address width (1024-word memory).
- `RESET_PC`, 0: fetch address after reset.

- `clk1`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `imem_req`, out, 1: read request this cycle.
- `imem_addr`, out, AW: word address of the request (equals PC).
- `imem_rdata`, in, 32: read data, valid exactly one cycle after `imem_req`.
- `redirect`, in, 1: taken branch from EX/MEM; flush and refetch.
- `redirect_pc`, in, AW: branch target word address.
- `halt`, in, 1: level; while high, no new requests are issued.
- `id_valid`, out, 1: head entry is presented to decode.
- `id_ir`, out, 32: head instruction.
- `id_npc`, out, 32: head address + 1, AW-bit wrap, zero-extended.
- `id_ready`, in, 1: decode accepts the head entry.
- `count`, out, log2(DEPTH)+1: current FIFO occupancy.

## Operation
- State:
  - PC (AW bits).
  - FIFO of DEPTH entries, each `{ir[31:0], npc[AW-1:0]}`, with read and write pointers and occupancy.
  - `inflight` flag and `inflight_npc`.
- Issue condition: `imem_req = !rst && !halt && !redirect && (count + inflight) < DEPTH`.
  - On issue: `inflight <= 1`, `inflight_npc <= PC+1`, `PC <= PC+1` (AW-bit wrap: 1023 -> 0).
  - Otherwise `inflight <= 0`.
- Response: in the cycle after an issue, `imem_rdata` is pushed with `inflight_npc`, unless `redirect` is high that cycle.
- Pop: an entry is popped when `id_valid && id_ready`.
- Simultaneous push and pop: occupancy is unchanged and the pointers advance independently.
- Overflow cannot occur: the issue condition reserves a slot for the in-flight word.
- `id_valid = (count != 0) && !redirect`. This is combinational on `redirect`, so decode never consumes during a flush cycle.
- `id_ir` and `id_npc` are driven from the head entry. When `count == 0` their values are don't-care; the bench must not check them.
- Redirect (highest priority) takes effect in the same cycle:
  - FIFO cleared (`count <= 0`, pointers reset).
  - Any in-flight response is dropped.
  - `PC <= redirect_pc`.
  - No request is issued in the redirect cycle.
  - A pop handshake in that cycle has no effect.
- Halt:
  - Stops new issue only.
  - An in-flight response is still pushed, and the FIFO continues to drain.
  - Deasserting `halt` resumes issue at the current PC.
- Redirect during halt: the flush and the PC update still occur; issue resumes when `halt` falls.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - PC = `RESET_PC`, `count` = 0, `inflight` = 0, pointers = 0.
  - `imem_req` = 0, `id_valid` = 0.
- Cycle 0: the first edge after `rst` falls; `imem_req` = 1 with `imem_addr` = `RESET_PC`.
- Latency: a request issued in cycle n is pushed at the end of cycle n+1 and visible on `id_valid` in cycle n+2.
- Throughput: 1 instruction per cycle sustained while `id_ready` is held at 1 and `halt` is 0.
- Redirect asserted in cycle r: the target request issues in cycle r+1, and the target instruction appears on `id_valid` in cycle r+3.
- Backpressure (`id_ready` = 0): `count` reaches DEPTH, then `imem_req` stays low until a pop frees a slot. The request is re-issued in the cycle after the pop.
- Reset asserted mid-operation discards all queued and in-flight words. No stale word ever appears after reset release.

## Test plan
- **Stream:** `Mem[i] = 0x1000_0000+i`; release reset; hold `id_ready` = 1.
  - `id_valid` rises in cycle 2.
  - Accepted pairs are (0x10000000, 1), (0x10000001, 2), (0x10000002, 3), … with no gaps.
- **Backpressure:** hold `id_ready` = 0 for 10 cycles.
  - `count` saturates at 4 and `imem_req` goes low with PC = 4.
  - After `id_ready` = 1, words 0..7 are delivered in order, with no loss or duplicate.
- **Redirect flush:** with 3 entries queued and 1 in flight, pulse `redirect` with `redirect_pc` = 0x200.
  - `id_valid` = 0 in the redirect cycle.
  - The next accepted entry is (`Mem[0x200]`, npc 0x201); stale words never appear.
- **Halt:** assert `halt` with 2 entries queued and 1 in flight.
  - 3 entries are delivered, then `id_valid` = 0 and `imem_req` = 0.
  - After `halt` falls, fetch resumes at the next sequential address.
- **Wrap:** redirect to 1023.
  - Delivered entries are (`Mem[1023]`, npc 0), then (`Mem[0]`, npc 1).
- **Async reset mid-run:** with the FIFO full, assert `rst` between clock edges.
  - `id_valid` and `count` go to 0 immediately.
  - After release, the first entry delivered is `Mem[RESET_PC]`.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: synchronous imem port feeding a small prefetch
// FIFO that presents {IR, NPC} pairs to decode over valid/ready.
// Taken-branch redirect flushes everything in the same cycle; halt only
// stops new requests while the queue keeps draining.
module mips32_fetch_queue #(
  parameter int              DEPTH    = 4,   // power of 2, >= 2
  parameter int              AW       = 10,  // word-address width, <= 32
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                     clk1,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic                     id_valid,
  output logic [31:0]              id_ir,
  output logic [31:0]              id_npc,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_npc_q, inflight_npc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage carries no reset: pointers and count define what is live.
  logic [31:0]   fifo_ir_q  [DEPTH];
  logic [AW-1:0] fifo_npc_q [DEPTH];

  logic          issue, push, pop, valid;
  logic [CW:0]   occupancy;

  // Issue/push/pop decisions and next-state; redirect overrides everything.
  always_comb begin
    // The in-flight word already owns a slot, so it counts toward occupancy.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = !rst && !halt && !redirect && (occupancy < (CW+1)'(DEPTH));
    valid     = (count_q != '0) && !redirect;
    pop       = valid && id_ready;
    push      = inflight_q && !redirect;

    pc_d           = pc_q;
    inflight_d     = inflight_q;
    inflight_npc_d = inflight_npc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;

    if (redirect) begin
      // Flush: drop queued and in-flight words, refetch from the target.
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        inflight_d     = 1'b1;
        inflight_npc_d = pc_q + AW'(1);
        pc_d           = pc_q + AW'(1);
      end else begin
        inflight_d     = 1'b0;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_npc_q <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflight_npc_q <= inflight_npc_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
    end
  end

  // Capture the returning imem word alongside its fall-through address.
  always_ff @(posedge clk1) begin
    if (push) begin
      fifo_ir_q[wr_ptr_q]  <= imem_rdata;
      fifo_npc_q[wr_ptr_q] <= inflight_npc_q;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign id_valid  = valid;
  assign id_ir     = fifo_ir_q[rd_ptr_q];
  assign id_npc    = {{(32-AW){1'b0}}, fifo_npc_q[rd_ptr_q]};
  assign count     = count_q;

endmodule
